// File: rtl/fetch_pc_queue.sv
// Fetch-address queue between the next-PC stage and the I-cache request port.
// Holds {pc, npc} pairs in a power-of-two ring buffer and drops all of them on a redirect flush.
module fetch_pc_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   pc_valid_i,
    input  logic [PC_W-1:0]        pc_i,
    input  logic [PC_W-1:0]        npc_i,
    output logic                   stall_o,
    output logic                   req_valid_o,
    output logic [PC_W-1:0]        req_pc_o,
    output logic [PC_W-1:0]        req_npc_o,
    input  logic                   req_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PC_W-1:0] pc_mem  [DEPTH];
    logic [PC_W-1:0] npc_mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Full/stall come only from registered count, so no path from req_ready_i to stall_o.
    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);

    assign stall_o     = full;
    assign req_valid_o = ~empty & ~flush_i;
    assign req_pc_o    = pc_mem[rd_ptr_q];
    assign req_npc_o   = npc_mem[rd_ptr_q];
    assign count_o     = count_q;

    assign push = pc_valid_i & ~full & ~flush_i;
    assign pop  = req_valid_o & req_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= pc_i;
            npc_mem[wr_ptr_q] <= npc_i;
        end
    end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue (DEPTH=4): vector table plus flush, wrap and
// async-reset sequences.
module tb_fetch_pc_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        pv;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        stall;
    logic        req_valid;
    logic [31:0] req_pc;
    logic [31:0] req_npc;
    logic        rdy;
    logic [2:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_pc_queue #(
        .DEPTH (4),
        .PC_W  (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .pc_valid_i  (pv),
        .pc_i        (pc),
        .npc_i       (npc),
        .stall_o     (stall),
        .req_valid_o (req_valid),
        .req_pc_o    (req_pc),
        .req_npc_o   (req_npc),
        .req_ready_i (rdy),
        .count_o     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        pv;
        logic [31:0] pc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [2:0]  ecnt;
        logic        est;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge; outputs are then sampled mid-cycle.
    task automatic step(input logic f, input logic v, input logic [31:0] p, input logic r);
        @(negedge clk);
        flush = f;
        pv    = v;
        pc    = p;
        npc   = p + 32'h40;
        rdy   = r;
        #1;
    endtask

    logic [31:0] model[$];

    initial begin
        int pushed;
        int popped;
        int cyc;
        int sz;

        rst_n = 1'b0;
        flush = 1'b0;
        pv    = 1'b0;
        pc    = '0;
        npc   = '0;
        rdy   = 1'b0;
        #3;
        chk("reset_valid", 64'(req_valid), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //          flush pv pc            rdy ev epc           cnt est
        vecs[0]  = '{1'b0, 1'b1, 32'h1c000000, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h1c000004, 1'b1, 1'b1, 32'h1c000000, 3'd1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h1c000008, 1'b1, 1'b1, 32'h1c000004, 3'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000008, 3'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h104,      1'b0, 1'b1, 32'h100,      3'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h108,      1'b0, 1'b1, 32'h100,      3'd2, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h10c,      1'b0, 1'b1, 32'h100,      3'd3, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h110,      1'b0, 1'b1, 32'h100,      3'd4, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h110,      1'b0, 1'b1, 32'h100,      3'd4, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'h110,      1'b1, 1'b1, 32'h100,      3'd4, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h110,      1'b0, 1'b1, 32'h104,      3'd3, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      3'd4, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h108,      3'd3, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10c,      3'd2, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h110,      3'd1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        3'd0, 1'b0};

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].flush, vecs[i].pv, vecs[i].pc, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), 64'(req_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ecnt));
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].est));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_pc", i), 64'(req_pc), 64'(vecs[i].epc));
                chk($sformatf("vec%0d_npc", i), 64'(req_npc), 64'(vecs[i].epc + 32'h40));
            end
        end

        // Wrap-around: 10 pushes, ready toggling, checked against a queue model.
        pushed = 0;
        popped = 0;
        cyc    = 0;
        while ((pushed < 10 || model.size() != 0) && cyc < 200) begin
            step(1'b0, pushed < 10, 32'h200 + 32'(4 * pushed), (cyc % 2) == 0);
            sz = model.size();
            chk("wrap_count", 64'(count), 64'(sz));
            chk("wrap_count_le4", 64'(count <= 3'd4), 64'd1);
            chk("wrap_valid", 64'(req_valid), 64'(sz != 0));
            chk("wrap_stall", 64'(stall), 64'(sz == 4));
            if (sz != 0 && rdy) begin
                chk("wrap_pc", 64'(req_pc), 64'(model[0]));
                chk("wrap_npc", 64'(req_npc), 64'(model[0] + 32'h40));
                void'(model.pop_front());
                popped++;
            end
            if (pv && sz < 4) begin
                model.push_back(pc);
                pushed++;
            end
            cyc++;
        end
        chk("wrap_done_in_budget", 64'(cyc < 200), 64'd1);
        chk("wrap_popped", 64'(popped), 64'd10);

        // Flush with 3 entries, concurrent push and ready.
        step(1'b0, 1'b1, 32'h280, 1'b0);
        step(1'b0, 1'b1, 32'h284, 1'b0);
        step(1'b0, 1'b1, 32'h288, 1'b0);
        step(1'b1, 1'b1, 32'h300, 1'b1);
        chk("flush_cycle_valid", 64'(req_valid), 64'd0);
        chk("flush_cycle_count", 64'(count), 64'd3);
        step(1'b0, 1'b1, 32'h400, 1'b0);
        chk("post_flush_count", 64'(count), 64'd0);
        chk("post_flush_valid", 64'(req_valid), 64'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("post_flush_push_valid", 64'(req_valid), 64'd1);
        chk("post_flush_push_pc", 64'(req_pc), 64'h400);
        chk("post_flush_push_count", 64'(count), 64'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("flush_drain_count", 64'(count), 64'd0);

        // Asynchronous reset between clock edges with 2 entries queued.
        step(1'b0, 1'b1, 32'h500, 1'b0);
        step(1'b0, 1'b1, 32'h504, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_reset_count", 64'(count), 64'd2);
        chk("pre_reset_pc", 64'(req_pc), 64'h500);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(req_valid), 64'd0);
        chk("mid_reset_stall", 64'(stall), 64'd0);
        chk("mid_reset_count", 64'(count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("after_reset_valid", 64'(req_valid), 64'd0);
        chk("after_reset_count", 64'(count), 64'd0);
        step(1'b0, 1'b1, 32'h600, 1'b1);
        chk("after_reset_push_valid", 64'(req_valid), 64'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("after_reset_head_valid", 64'(req_valid), 64'd1);
        chk("after_reset_head_pc", 64'(req_pc), 64'h600);
        chk("after_reset_head_count", 64'(count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_queue.md
# fetch_pc_queue

Buffers fetch addresses produced by the next-PC stage and hands them to the instruction-cache request port through a valid/ready handshake. Each entry carries the fetch PC and its predicted next PC. The block back-pressures the PC stage with a stall when it is full. A redirect flush drops every entry in flight.

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥ 2.
- `PC_W`, default 32: PC width.

- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `flush_i` in 1: redirect/flush. Clears the queue.
- `pc_valid_i` in 1: PC stage presents a new fetch address this cycle.
- `pc_i` in PC_W: fetch PC from the PC stage.
- `npc_i` in PC_W: predicted next PC for `pc_i`.
- `stall_o` out 1: to the PC stage's stall input; hold the current PC.
- `req_valid_o` out 1: head entry valid toward the I-cache.
- `req_pc_o` out PC_W: head entry fetch PC.
- `req_npc_o` out PC_W: head entry predicted next PC.
- `req_ready_i` in 1: I-cache accepts the head this cycle.
- `count_o` out log2(DEPTH)+1: current occupancy.

## Operation
- State:
  - storage array of DEPTH × {pc, npc};
  - `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - `count`, log2(DEPTH)+1 bits.
- `full` = (count == DEPTH). `empty` = (count == 0).
- `stall_o` = full. It depends only on registered state; no combinational path from `req_ready_i`.
- push = `pc_valid_i` & ~full & ~`flush_i`.
  - Writes {`pc_i`, `npc_i`} at `wr_ptr`.
  - `wr_ptr` increments.
- pop = `req_valid_o` & `req_ready_i`.
  - `rd_ptr` increments.
- `req_valid_o` = ~empty & ~`flush_i`. A flush cycle never hands out an entry.
- `req_pc_o` / `req_npc_o` = storage[`rd_ptr`]. Value is don't-care when `req_valid_o` is 0.
- count update on a non-flush cycle: count + push − pop.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
- Full with pop in the same cycle: no push. `stall_o` is already high, so the PC stage holds its PC. Next cycle count = DEPTH−1 and `stall_o` drops.
- No duplicate PCs: the PC stage holds its PC while `stall_o` is high, and a held PC is never pushed twice because push requires ~full.
- `flush_i`:
  - next state is `wr_ptr` = `rd_ptr` = 0, count = 0;
  - the `pc_i` presented in the flush cycle is discarded;
  - flush overrides push and pop in the same cycle.
- No bypass: an entry is visible at the head no earlier than the cycle after it is pushed.
- Pointer wrap: after entry DEPTH−1, the next write/read goes to index 0. No special case.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `wr_ptr` = `rd_ptr` = 0, count = 0;
  - `stall_o` = 0, `req_valid_o` = 0, `count_o` = 0;
  - storage contents need no reset.
- Reset asserted mid-operation drops all entries, identical to power-up.
- Push-to-request latency: 1 cycle. Push at cycle N gives `req_valid_o` = 1 at N+1 if the entry is at the head.
- Full-to-stall latency: 0 cycles after the registered count reaches DEPTH. The DEPTH-th push at cycle N gives `stall_o` = 1 at N+1.
- Flush latency:
  - `req_valid_o` = 0 in the flush cycle itself;
  - queue empty from cycle N+1;
  - first post-flush push can occur at N+1.
- The PC stage's redirect has priority over `stall_o` in the PC stage. A redirect is always accompanied by `flush_i`, so the queue never holds wrong-path PCs beyond the flush.
- Handshake rules:
  - head data must stay stable while `req_valid_o` = 1 and `req_ready_i` = 0, unless flushed;
  - `req_ready_i` may depend combinationally on `req_valid_o`.

## Test plan
- **Reset release, ready=1:**
  - stimulus: `pc_valid_i` = 1 with pc 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles;
  - required: `req_pc_o` shows each value one cycle later with `req_valid_o` = 1; count_o stays ≤ 1; `stall_o` never asserts.
- **Fill to full, ready=0, DEPTH=4:**
  - stimulus: push pc 0x100, 0x104, 0x108, 0x10c;
  - required: count_o = 4 and `stall_o` = 1 on the cycle after the fourth push; a fifth `pc_i` 0x110 presented while full is not stored; head stays 0x100.
- **Full with pop:**
  - stimulus: from the full state, raise `req_ready_i` for one cycle while `pc_valid_i` = 1 with 0x110;
  - required: 0x100 is consumed and 0x110 is not pushed that cycle; next cycle count_o = 3, `stall_o` = 0, head 0x104; 0x110 is pushed the following cycle.
- **Wrap-around:**
  - stimulus: 10 pushes with ready toggling 1/0;
  - required: outputs appear in exact push order 0x200..0x224; count_o never exceeds 4.
- **Flush with 3 entries:**
  - stimulus: 3 entries queued, then `flush_i` together with push 0x300 and `req_ready_i` = 1;
  - required: `req_valid_o` = 0 in that cycle; next cycle count_o = 0; a push of 0x400 appears at head one cycle after its push.
- **Async reset mid-stream:**
  - stimulus: 2 entries queued, `rst_n` pulsed low between clock edges;
  - required: `req_valid_o`, `stall_o` and count_o go to 0 immediately and remain 0 until a new push.
